// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared types and defaults for the sequential scan encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int IDX_W_DEF = 4;

    typedef enum logic [0:0] {
        ENC_IDLE = 1'b0,
        ENC_SCAN = 1'b1
    } enc_state_t;

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/encoder_prio.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_prio
//  Description : Combinational first-set-bit finder, lowest or highest first.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_prio #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    input  logic             msb_first,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            int j;
            j = msb_first ? (WIDTH - 1 - i) : i;
            if (!any && mask[j]) begin
                index = IDX_W'(j);
                any   = 1'b1;
            end
        end
    end

endmodule : encoder_prio
`default_nettype wire

// File: rtl/encoder_scan.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_scan
//  Description : Sequential multi-hot to binary encoder, one index per handshake.
//                Optional macro ENCODER_SCAN_COUNT_EN adds a popcount output.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_scan
    import encoder_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] req_in,
    input  logic             load_in,
    output logic             load_ready,
    output logic             busy,
    output logic [IDX_W-1:0] binary_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
`ifdef ENCODER_SCAN_COUNT_EN
    ,
    output logic [IDX_W:0]   count_out
`endif
);

    enc_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mask, w_mask_nxt;
    logic [IDX_W-1:0] r_binary, w_binary_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_mask_clr;
    logic [IDX_W-1:0] w_load_idx, w_adv_idx;
    logic             w_load_any, w_adv_any;
    logic             w_load_acc, w_handshake;

    // Load path looks at the incoming vector, advance path at the mask
    // with the index being emitted this cycle already removed.
    assign w_mask_clr = r_mask & ~(WIDTH'(1) << r_binary);

    encoder_prio #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_prio_load (
        .mask      (req_in),
        .msb_first (MSB_FIRST),
        .index     (w_load_idx),
        .any       (w_load_any)
    );

    encoder_prio #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_prio_adv (
        .mask      (w_mask_clr),
        .msb_first (MSB_FIRST),
        .index     (w_adv_idx),
        .any       (w_adv_any)
    );

    assign w_load_acc  = enable && load_in && (r_state == ENC_IDLE);
    assign w_handshake = enable && (r_state == ENC_SCAN) && r_valid && out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_binary_nxt = r_binary;
        w_valid_nxt  = r_valid;
        w_done_nxt   = 1'b0;
        case (r_state)
            ENC_IDLE: begin
                if (w_load_acc) begin
                    if (w_load_any) begin
                        w_mask_nxt   = req_in;
                        w_binary_nxt = w_load_idx;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = ENC_SCAN;
                    end else begin
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            ENC_SCAN: begin
                if (w_handshake) begin
                    w_mask_nxt = w_mask_clr;
                    if (w_adv_any) begin
                        w_binary_nxt = w_adv_idx;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ENC_IDLE;
                    end
                end
            end
            default: w_state_nxt = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ENC_IDLE;
            r_mask   <= '0;
            r_binary <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_binary <= w_binary_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign busy       = (r_state == ENC_SCAN);
    assign load_ready = ~busy;
    assign binary_out = r_binary;
    assign out_valid  = r_valid & enable;
    assign done       = r_done;

`ifdef ENCODER_SCAN_COUNT_EN
    logic [IDX_W:0] w_pop;
    logic [IDX_W:0] r_count;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + (IDX_W + 1)'(req_in[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_load_acc) begin
            r_count <= w_pop;
        end
    end

    assign count_out = r_count;
`endif

endmodule : encoder_scan
`default_nettype wire

// File: tb/tb_encoder_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_scan
//  Description : Self-checking bench for encoder_scan, ascending and descending.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_scan;

    logic        clk = 1'b0;
    logic        reset, enable, load_in, out_ready;
    logic [15:0] req_in;

    logic        a_load_ready, a_busy, a_valid, a_done;
    logic [3:0]  a_bin;
    logic        d_load_ready, d_busy, d_valid, d_done;
    logic [3:0]  d_bin;
`ifdef ENCODER_SCAN_COUNT_EN
    logic [4:0]  a_count, d_count;
`endif

    always #5 clk = ~clk;

    encoder_scan #(.WIDTH(16), .MSB_FIRST(1'b0)) u_dut_asc (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_in     (req_in),
        .load_in    (load_in),
        .load_ready (a_load_ready),
        .busy       (a_busy),
        .binary_out (a_bin),
        .out_valid  (a_valid),
        .out_ready  (out_ready),
        .done       (a_done)
`ifdef ENCODER_SCAN_COUNT_EN
        ,
        .count_out  (a_count)
`endif
    );

    encoder_scan #(.WIDTH(16), .MSB_FIRST(1'b1)) u_dut_desc (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_in     (req_in),
        .load_in    (load_in),
        .load_ready (d_load_ready),
        .busy       (d_busy),
        .binary_out (d_bin),
        .out_valid  (d_valid),
        .out_ready  (out_ready),
        .done       (d_done)
`ifdef ENCODER_SCAN_COUNT_EN
        ,
        .count_out  (d_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a pending-bit set per DUT; the emitted index is its
    // lowest (ascending) or highest (descending) member.
    logic [15:0] pm_a = '0, pm_d = '0;
    logic        done_m = 1'b0;
    logic [4:0]  cnt_m = '0;

    function automatic logic [3:0] lowest(input logic [15:0] x);
        logic [15:0] t;
        t = x & (~x + 16'd1);
        return 4'($clog2(t));
    endfunction

    function automatic logic [3:0] highest(input logic [15:0] x);
        return 4'($clog2({1'b0, x} + 17'd1) - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic eb;
        eb = (pm_a != 16'd0);
        check("busy_a",  32'(a_busy), 32'(eb));
        check("busy_d",  32'(d_busy), 32'(eb));
        check("lrdy_a",  32'(a_load_ready), 32'(!eb));
        check("lrdy_d",  32'(d_load_ready), 32'(!eb));
        check("valid_a", 32'(a_valid), 32'(eb && enable));
        check("valid_d", 32'(d_valid), 32'(eb && enable));
        check("done_a",  32'(a_done), 32'(done_m));
        check("done_d",  32'(d_done), 32'(done_m));
        if (eb) begin
            check("bin_a", 32'(a_bin), 32'(lowest(pm_a)));
            check("bin_d", 32'(d_bin), 32'(highest(pm_d)));
        end
`ifdef ENCODER_SCAN_COUNT_EN
        check("count_a", 32'(a_count), 32'(cnt_m));
        check("count_d", 32'(d_count), 32'(cnt_m));
`endif
    endtask

    task automatic step();
        logic [15:0] na, nd;
        logic        ndone;
        logic [4:0]  ncnt;
        na = pm_a; nd = pm_d; ndone = 1'b0; ncnt = cnt_m;
        if (reset) begin
            na = '0; nd = '0; ncnt = '0;
        end else if (enable) begin
            if (pm_a == 16'd0) begin
                if (load_in) begin
                    na = req_in; nd = req_in;
                    ncnt = 5'($countones(req_in));
                    ndone = (req_in == 16'd0);
                end
            end else if (out_ready) begin
                na = pm_a & ~(16'd1 << lowest(pm_a));
                nd = pm_d & ~(16'd1 << highest(pm_d));
                ndone = (na == 16'd0);
            end
        end
        @(posedge clk);
        pm_a = na; pm_d = nd; done_m = ndone; cnt_m = ncnt;
        #1;
        check_model();
    endtask

    typedef struct {
        logic [15:0] req;
        int          n_idx;
        logic [3:0]  first_a;
        logic [3:0]  first_d;
        logic [4:0]  pop;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h0001, 1,  4'd0,  4'd0,  5'd1};
        vecs[1] = '{16'h8421, 4,  4'd0,  4'd15, 5'd4};
        vecs[2] = '{16'h00C0, 2,  4'd6,  4'd7,  5'd2};
        vecs[3] = '{16'h0000, 0,  4'd0,  4'd0,  5'd0};
        vecs[4] = '{16'hFFFF, 16, 4'd0,  4'd15, 5'd16};
        vecs[5] = '{16'h8000, 1,  4'd15, 4'd15, 5'd1};

        reset = 1'b1; enable = 1'b1; load_in = 1'b0; out_ready = 1'b1; req_in = '0;
        #1;
        step();
        step();
        check("rst_bin_a",  32'(a_bin), 0);
        check("rst_bin_d",  32'(d_bin), 0);
        check("rst_valid",  32'(a_valid | d_valid), 0);
        check("rst_busy",   32'(a_busy | d_busy), 0);
        check("rst_done",   32'(a_done | d_done), 0);
        check("rst_lrdy",   32'(a_load_ready & d_load_ready), 1);
        reset = 1'b0;

        // Table-driven single scans with the consumer always ready.
        for (int v = 0; v < 6; v++) begin
            int  hs;
            bit  seen_done;
            logic [3:0] fa, fd;
            hs = 0; seen_done = 0; fa = '0; fd = '0;
            req_in = vecs[v].req; load_in = 1'b1; out_ready = 1'b1;
            step();
            load_in = 1'b0;
            for (int c = 0; c < 40 && !seen_done; c++) begin
                if (a_valid) begin
                    if (hs == 0) begin fa = a_bin; fd = d_bin; end
                    hs++;
                end
                if (a_done) seen_done = 1;
                else step();
            end
            check("tbl_done", 32'(seen_done), 1);
            check("tbl_nidx", 32'(hs), 32'(vecs[v].n_idx));
            if (vecs[v].n_idx > 0) begin
                check("tbl_first_a", 32'(fa), 32'(vecs[v].first_a));
                check("tbl_first_d", 32'(fd), 32'(vecs[v].first_d));
            end
`ifdef ENCODER_SCAN_COUNT_EN
            check("tbl_count", 32'(a_count), 32'(vecs[v].pop));
`endif
            step();
        end

        // 0x8421 back to back, with load_in held high during the scan.
        begin
            logic [3:0] ea[4];
            logic [3:0] ed[4];
            ea = '{4'd0, 4'd5, 4'd10, 4'd15};
            ed = '{4'd15, 4'd10, 4'd5, 4'd0};
            req_in = 16'h8421; load_in = 1'b1;
            step();
            req_in = 16'hFFFF;
            for (int k = 0; k < 4; k++) begin
                check("seq_bin_a", 32'(a_bin), 32'(ea[k]));
                check("seq_bin_d", 32'(d_bin), 32'(ed[k]));
                check("seq_busy",  32'(a_busy && a_valid), 1);
                if (k == 3) load_in = 1'b0;
                step();
            end
            check("seq_done",  32'(a_done && d_done), 1);
            check("seq_nvalid", 32'(a_valid | d_valid), 0);
            step();
        end

        // Stall: index held while out_ready is low.
        req_in = 16'h00C0; load_in = 1'b1; out_ready = 1'b0;
        step();
        load_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_bin_a", 32'(a_bin), 6);
            check("stall_bin_d", 32'(d_bin), 7);
            check("stall_valid", 32'(a_valid), 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        step();
        check("rel_bin_a", 32'(a_bin), 7);
        check("rel_bin_d", 32'(d_bin), 6);
        step();
        check("rel_done", 32'(a_done), 1);
        step();

        // Enable low mid-scan freezes the index and masks out_valid.
        req_in = 16'h0104; load_in = 1'b1;
        step();
        load_in = 1'b0; enable = 1'b0;
        #1;
        check("en_valid", 32'(a_valid | d_valid), 0);
        step();
        step();
        check("en_bin_a", 32'(a_bin), 2);
        check("en_bin_d", 32'(d_bin), 8);
        check("en_busy",  32'(a_busy), 1);
        enable = 1'b1;
        #1;
        check("en_resume", 32'(a_valid), 1);
        step();
        check("en_next_a", 32'(a_bin), 8);
        step();
        step();

        // Reset in the middle of a 0xFFFF scan.
        req_in = 16'hFFFF; load_in = 1'b1;
        step();
        load_in = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        check("mrst_bin",   32'(a_bin | d_bin), 0);
        check("mrst_valid", 32'(a_valid | d_valid), 0);
        check("mrst_busy",  32'(a_busy | d_busy), 0);
        check("mrst_done",  32'(a_done | d_done), 0);
        reset = 1'b0;
        req_in = 16'h0006; load_in = 1'b1;
        step();
        load_in = 1'b0;
        check("fresh_bin_a", 32'(a_bin), 1);
        check("fresh_bin_d", 32'(d_bin), 2);
        step(); step(); step();

        // Randomized traffic against the reference.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(199) == 0);
            enable    = ($urandom_range(9) != 0);
            load_in   = ($urandom_range(2) == 0);
            out_ready = ($urandom_range(3) != 0);
            case ($urandom_range(3))
                0:       req_in = 16'h0000;
                1:       req_in = 16'd1 << $urandom_range(15);
                default: req_in = 16'($urandom);
            endcase
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_encoder_scan
`default_nettype wire
